// File: rtl/mult_wb_buffer_pkg.sv
// Shared types for the multiply/divide result writeback buffer.
// Entry widths follow the default XLEN/TRANS_ID_BITS of mult_wb_buffer.
package mult_wb_buffer_pkg;

  localparam int unsigned DEF_XLEN          = 64;
  localparam int unsigned DEF_TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [DEF_XLEN-1:0]          result;
    logic [DEF_TRANS_ID_BITS-1:0] trans_id;
  } wb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

endpackage

// File: rtl/mult_wb_buffer_fifo.sv
// Generic synchronous FIFO with simultaneous push/pop, synchronous flush and
// a drop indication for a push that finds the FIFO full with no pop.
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_c,
  output logic                     empty_c,
  output logic                     drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en;
  logic             pop_en;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en = push_i && (!full_c || pop_i);
  assign pop_en  = pop_i && !empty_c;
  assign drop_c  = push_i && full_c && !pop_i;

  assign head_c  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

endmodule

// File: rtl/mult_wb_buffer.sv
// Receives unstallable mult/div result beats into a FIFO, hands them to the
// scoreboard with backpressure, and meters issue with credits.
module mult_wb_buffer
  import mult_wb_buffer_pkg::*;
#(
  parameter int unsigned XLEN          = DEF_XLEN,
  parameter int unsigned TRANS_ID_BITS = DEF_TRANS_ID_BITS,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned MUL_LAT       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  output logic                     issue_ok_o,
  input  logic                     mult_valid_i,
  input  logic [XLEN-1:0]          mult_result_i,
  input  logic [TRANS_ID_BITS-1:0] mult_trans_id_i,
  output logic                     wb_valid_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  input  logic                     wb_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned DRAIN_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  wb_state_e          state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]   credits_q;
  logic               overflow_q;

  wb_entry_t          push_entry;
  wb_entry_t          head_entry;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;

  logic               run;
  logic               push;
  logic               pop;
  logic               issue;

  // Flush overrides every other event in the cycle it is seen.
  assign run   = (state_q == RUN);
  assign push  = mult_valid_i && run && !flush_i;
  assign pop   = wb_valid_o && wb_ready_i && !flush_i;
  assign issue = issue_valid_i && issue_ok_o && !flush_i;

  assign push_entry.result   = mult_result_i;
  assign push_entry.trans_id = mult_trans_id_i;

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .head_c  (head_entry),
    .count_o (fifo_count),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .drop_c  (fifo_drop)
  );

  assign issue_ok_o    = run && (credits_q != '0);
  assign wb_valid_o    = run && !fifo_empty;
  assign wb_result_o   = head_entry.result;
  assign wb_trans_id_o = head_entry.trans_id;
  assign count_o       = fifo_count;
  assign overflow_o    = overflow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Stay in DRAIN until results issued before the flush have emerged.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      RUN: begin
        if (flush_i) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_W'(MUL_LAT);
        end
      end
      DRAIN: begin
        if (flush_i) begin
          drain_cnt_d = DRAIN_W'(MUL_LAT);
        end else if (drain_cnt_q <= DRAIN_W'(1)) begin
          state_d     = RUN;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      credits_q <= CNT_W'(DEPTH);
    end else if (issue && !pop) begin
      credits_q <= credits_q - CNT_W'(1);
    end else if (pop && !issue) begin
      credits_q <= credits_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if (fifo_drop) begin
      overflow_q <= 1'b1;
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Directed vector table plus randomized run against a queue-based model.
module tb_mult_wb_buffer;
  import mult_wb_buffer_pkg::*;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned TID     = 3;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MUL_LAT = 2;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            issue_valid_i;
  logic            issue_ok_o;
  logic            mult_valid_i;
  logic [XLEN-1:0] mult_result_i;
  logic [TID-1:0]  mult_trans_id_i;
  logic            wb_valid_o;
  logic [XLEN-1:0] wb_result_o;
  logic [TID-1:0]  wb_trans_id_o;
  logic            wb_ready_i;
  logic [2:0]      count_o;
  logic            overflow_o;

  int checks = 0;
  int errors = 0;

  mult_wb_buffer #(
    .XLEN (XLEN), .TRANS_ID_BITS (TID), .DEPTH (DEPTH), .MUL_LAT (MUL_LAT)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ok_o      (issue_ok_o),
    .mult_valid_i    (mult_valid_i),
    .mult_result_i   (mult_result_i),
    .mult_trans_id_i (mult_trans_id_i),
    .wb_valid_o      (wb_valid_o),
    .wb_result_o     (wb_result_o),
    .wb_trans_id_o   (wb_trans_id_o),
    .wb_ready_i      (wb_ready_i),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          fl;
    bit          iss;
    bit          mv;
    logic [63:0] res;
    logic [2:0]  id;
    bit          rdy;
    bit          e_ok;
    bit          e_val;
    logic [63:0] e_res;
    logic [2:0]  e_id;
    int          e_cnt;
    bit          e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit fl, input bit iss, input bit mv,
                              input logic [63:0] res, input logic [2:0] id,
                              input bit rdy, input bit e_ok, input bit e_val,
                              input logic [63:0] e_res, input logic [2:0] e_id,
                              input int e_cnt, input bit e_ovf);
    vec_t v;
    v.fl = fl; v.iss = iss; v.mv = mv; v.res = res; v.id = id; v.rdy = rdy;
    v.e_ok = e_ok; v.e_val = e_val; v.e_res = e_res; v.e_id = e_id;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input bit ok, input bit val,
                            input logic [63:0] res, input logic [2:0] id,
                            input int cnt, input bit ovf);
    chk({tag, ".issue_ok"}, 64'(issue_ok_o), 64'(ok));
    chk({tag, ".wb_valid"}, 64'(wb_valid_o), 64'(val));
    chk({tag, ".count"}, 64'(count_o), 64'(cnt));
    chk({tag, ".overflow"}, 64'(overflow_o), 64'(ovf));
    if (val) begin
      chk({tag, ".result"}, wb_result_o, res);
      chk({tag, ".trans_id"}, 64'(wb_trans_id_o), 64'(id));
    end
  endtask

  task automatic apply(input bit fl, input bit iss, input bit mv,
                       input logic [63:0] res, input logic [2:0] id, input bit rdy);
    flush_i         = fl;
    issue_valid_i   = iss;
    mult_valid_i    = mv;
    mult_result_i   = res;
    mult_trans_id_i = id;
    wb_ready_i      = rdy;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    apply(v.fl, v.iss, v.mv, v.res, v.id, v.rdy);
    @(negedge clk_i);
    check_outs(tag, v.e_ok, v.e_val, v.e_res, v.e_id, v.e_cnt, v.e_ovf);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 64'h0, 3'h0, 1'b0);
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b0;
  endtask

  // Reference model: FIFO contents as a queue, credits as an integer, and
  // the blocked window after a flush as the last cycle number that is blocked.
  wb_entry_t mq[$];
  int        m_credits;
  int        m_cyc;
  int        m_blk;
  bit        m_ovf;
  int        outstanding;

  function automatic bit m_run();
    return m_cyc > m_blk;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_credits   = DEPTH;
    m_cyc       = 0;
    m_blk       = -1;
    m_ovf       = 1'b0;
    outstanding = 0;
  endtask

  bit          r_rst, r_fl, r_iss, r_rdy, r_mv;
  bit          e_ok, e_val, iss_h, pop_h, push_h;
  logic [63:0] r_res, e_res;
  logic [2:0]  r_id, e_id;
  int          sz;
  wb_entry_t   ent;

  initial begin
    do_reset();

    // Reset values, including the held head data.
    chk("reset.result", wb_result_o, 64'h0);
    chk("reset.trans_id", 64'(wb_trans_id_o), 64'h0);

    // Basic path, credit limit, full with simultaneous push/pop, ordering.
    vecs.push_back(mk(0,0,0,64'h0,0,1,          1,0,64'h0,0,0,0));
    vecs.push_back(mk(0,1,1,64'hDEAD_BEEF,3,1,  1,0,64'h0,0,0,0));
    vecs.push_back(mk(0,0,0,64'h0,0,1,          1,1,64'hDEAD_BEEF,3,1,0));
    vecs.push_back(mk(0,0,0,64'h0,0,1,          1,0,64'h0,0,0,0));
    vecs.push_back(mk(0,1,0,64'h0,0,0,          1,0,64'h0,0,0,0));
    vecs.push_back(mk(0,1,0,64'h0,0,0,          1,0,64'h0,0,0,0));
    vecs.push_back(mk(0,1,0,64'h0,0,0,          1,0,64'h0,0,0,0));
    vecs.push_back(mk(0,1,0,64'h0,0,0,          1,0,64'h0,0,0,0));
    vecs.push_back(mk(0,1,1,64'h10,0,0,         0,0,64'h0,0,0,0));
    vecs.push_back(mk(0,0,1,64'h11,1,0,         0,1,64'h10,0,1,0));
    vecs.push_back(mk(0,0,1,64'h12,2,0,         0,1,64'h10,0,2,0));
    vecs.push_back(mk(0,0,1,64'h13,3,0,         0,1,64'h10,0,3,0));
    vecs.push_back(mk(0,0,1,64'h14,4,1,         0,1,64'h10,0,4,0));
    vecs.push_back(mk(0,1,0,64'h0,0,0,          1,1,64'h11,1,4,0));
    vecs.push_back(mk(0,0,0,64'h0,0,1,          0,1,64'h11,1,4,0));
    vecs.push_back(mk(0,0,0,64'h0,0,1,          1,1,64'h12,2,3,0));
    vecs.push_back(mk(0,0,0,64'h0,0,1,          1,1,64'h13,3,2,0));
    vecs.push_back(mk(0,0,0,64'h0,0,1,          1,1,64'h14,4,1,0));
    vecs.push_back(mk(0,0,0,64'h0,0,0,          1,0,64'h0,0,0,0));
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("tbl%0d", i), vecs[i]);
    end

    // Flush with two entries queued; simultaneous push/pop/issue lose.
    do_reset();
    run_vec("fl0", mk(0,1,0,64'h0,0,0,      1,0,64'h0,0,0,0));
    run_vec("fl1", mk(0,1,1,64'h100,5,0,    1,0,64'h0,0,0,0));
    run_vec("fl2", mk(0,0,1,64'h200,6,0,    1,1,64'h100,5,1,0));
    run_vec("fl3", mk(1,1,1,64'h300,7,1,    1,1,64'h100,5,2,0));
    run_vec("fl4", mk(0,1,1,64'h400,0,1,    0,0,64'h0,0,0,0));
    run_vec("fl5", mk(0,1,1,64'h500,1,1,    0,0,64'h0,0,0,0));
    run_vec("fl6", mk(0,1,0,64'h0,0,1,      1,0,64'h0,0,0,0));
    run_vec("fl7", mk(0,1,0,64'h0,0,1,      1,0,64'h0,0,0,0));
    run_vec("fl8", mk(0,1,0,64'h0,0,1,      1,0,64'h0,0,0,0));
    run_vec("fl9", mk(0,1,0,64'h0,0,1,      1,0,64'h0,0,0,0));
    run_vec("fl10", mk(0,1,0,64'h0,0,1,     0,0,64'h0,0,0,0));
    // Flush again during DRAIN extends the blocked window.
    run_vec("fd0", mk(1,0,0,64'h0,0,1,      0,0,64'h0,0,0,0));
    run_vec("fd1", mk(1,0,0,64'h0,0,1,      0,0,64'h0,0,0,0));
    run_vec("fd2", mk(0,1,0,64'h0,0,1,      0,0,64'h0,0,0,0));
    run_vec("fd3", mk(0,1,1,64'h600,2,1,    0,0,64'h0,0,0,0));
    run_vec("fd4", mk(0,0,0,64'h0,0,1,      1,0,64'h0,0,0,0));
    run_vec("fd5", mk(0,0,0,64'h0,0,1,      1,0,64'h0,0,0,0));

    // Overflow: push into a full FIFO is dropped and the flag sticks.
    do_reset();
    run_vec("ov0", mk(0,1,0,64'h0,0,0,      1,0,64'h0,0,0,0));
    run_vec("ov1", mk(0,1,1,64'hA0,0,0,     1,0,64'h0,0,0,0));
    run_vec("ov2", mk(0,1,1,64'hA1,1,0,     1,1,64'hA0,0,1,0));
    run_vec("ov3", mk(0,1,1,64'hA2,2,0,     1,1,64'hA0,0,2,0));
    run_vec("ov4", mk(0,0,1,64'hA3,3,0,     0,1,64'hA0,0,3,0));
    run_vec("ov5", mk(0,0,1,64'hFF,7,0,     0,1,64'hA0,0,4,0));
    run_vec("ov6", mk(0,0,0,64'h0,0,1,      0,1,64'hA0,0,4,1));
    run_vec("ov7", mk(0,0,0,64'h0,0,1,      1,1,64'hA1,1,3,1));
    run_vec("ov8", mk(0,0,0,64'h0,0,1,      1,1,64'hA2,2,2,1));
    run_vec("ov9", mk(0,0,0,64'h0,0,1,      1,1,64'hA3,3,1,1));
    run_vec("ov10", mk(0,0,0,64'h0,0,0,     1,0,64'h0,0,0,1));
    do_reset();
    run_vec("ov11", mk(0,0,0,64'h0,0,0,     1,0,64'h0,0,0,0));

    // Randomized traffic against the model; results only follow issued ops.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_fl  = ($urandom_range(0, 29) == 0);
      r_iss = ($urandom_range(0, 1) == 1);
      r_rdy = ($urandom_range(0, 9) < 7);
      r_res = {$urandom(), $urandom()};
      r_id  = 3'($urandom_range(0, 7));
      r_mv  = 1'b0;
      if (!m_run()) r_mv = ($urandom_range(0, 2) == 0);
      else if (outstanding > 0) r_mv = ($urandom_range(0, 2) != 0);

      rst_i = r_rst;
      apply(r_fl, r_iss, r_mv, r_res, r_id, r_rdy);
      @(negedge clk_i);
      e_ok  = m_run() && (m_credits != 0);
      e_val = m_run() && (mq.size() > 0);
      e_res = e_val ? mq[0].result : 64'h0;
      e_id  = e_val ? mq[0].trans_id : 3'h0;
      check_outs("rand", e_ok, e_val, e_res, e_id, mq.size(), m_ovf);

      @(posedge clk_i);
      if (r_rst) begin
        model_reset();
      end else if (r_fl) begin
        mq.delete();
        m_credits   = DEPTH;
        m_blk       = m_cyc + MUL_LAT;
        outstanding = 0;
      end else begin
        iss_h  = r_iss && e_ok;
        pop_h  = e_val && r_rdy;
        push_h = r_mv && m_run();
        sz     = mq.size();
        if (iss_h) begin
          m_credits--;
          outstanding++;
        end
        if (pop_h) begin
          m_credits++;
          void'(mq.pop_front());
        end
        if (push_h) begin
          outstanding--;
          if (sz == DEPTH && !pop_h) begin
            m_ovf = 1'b1;
          end else begin
            ent.result   = r_res;
            ent.trans_id = r_id;
            mq.push_back(ent);
          end
        end
      end
      m_cyc++;
      #1;
    end
    rst_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
